mem_arbiter: RTL and testbench

- Two-requester arbiter/sequencer in front of the single-port, 16-bit, byte-addressable data_memory.
- Lets instruction fetch (I-port) and load/store (D-port) share one memory array.
- Models a fixed multi-cycle access latency: a request is latched, held busy for LATENCY cycles, then completed with a one-cycle ack.
- Drives the memory enable/write strobe for exactly one cycle per transaction, so a write is never repeated.

---
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (I/D) latency-modelling arbiter in front of a single-port 16-bit memory.
// Optional MEM_ARB_RR_EN selects round-robin tie-breaking instead of fixed D-over-I priority.
module mem_arbiter #(
    parameter int LATENCY    = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  d_ack,
    output logic [15:0]           rdata,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [15:0]           rdata_q, rdata_d;
    logic                  d_wins;
    logic                  strobe;
    logic                  accept;
    assign accept = (state_q == IDLE) && (i_req || d_req);
    assign strobe = (state_q == WAIT) && (cnt_q == 4'd1);
`ifdef MEM_ARB_RR_EN
    // rr_last: 0 = I, 1 = D; the port that did not win last time takes a tie
    logic rr_last_q;
    assign d_wins = d_req && (!i_req || !rr_last_q);
    always_ff @(posedge clk)
        rr_last_q <= rst ? 1'b0 : (accept ? d_wins : rr_last_q);
`else
    assign d_wins = d_req;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (accept) begin
                owner_d = d_wins;
                wr_d    = d_wins & d_wr;
                addr_d  = d_wins ? d_addr : i_addr;
                wdata_d = d_wins ? d_wdata : 16'h0000;
                cnt_d   = 4'(LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (strobe) begin
                    state_d = DONE;
                    rdata_d = wr_q ? rdata_q : mem_rdata;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    // strobe is gated by rst so a write landing in a reset cycle is dropped
    assign mem_en    = strobe && !rst;
    assign mem_wr    = mem_en && wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign busy      = state_q != IDLE;
    assign i_ack     = (state_q == DONE) && !owner_q;
    assign d_ack     = (state_q == DONE) && owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter (LATENCY=4 and LATENCY=2 instances) against a word memory model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_ack, d_ack, busy, mem_en, mem_wr;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i2_req = 1'b0;
    logic [15:0] i2_addr = '0;
    logic        i2_ack, d2_ack, busy2, mem_en2, mem_wr2;
    logic [15:0] rdata2, mem_addr2, mem_wdata2, mem_rdata2;
    logic [15:0] mem [0:255];
    int          checks = 0, failures = 0, wr_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(4), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.LATENCY(2), .ADDR_WIDTH(16)) dut2 (
        .clk(clk), .rst(rst),
        .i_req(i2_req), .i_addr(i2_addr), .i_ack(i2_ack),
        .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000), .d_ack(d2_ack),
        .rdata(rdata2), .busy(busy2),
        .mem_en(mem_en2), .mem_wr(mem_wr2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2)
    );

    assign mem_rdata  = mem[mem_addr[8:1]];
    assign mem_rdata2 = mem[mem_addr2[8:1]];

    initial for (int k = 0; k < 256; k++) mem[k] = {8'(k), ~8'(k)};

    always @(posedge clk)
        if (mem_en && mem_wr) begin
            mem[mem_addr[8:1]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_ack", {i_ack, d_ack}, 0);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_mem", {mem_en, mem_wr, mem_addr, mem_wdata}, 0);
        rst = 1'b0;
        // write BEEF to 0x0010: strobe at T+3, ack at T+4
        d_req = 1; d_wr = 1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
        chk("w_T_busy", busy, 0);
        tick(); chk("w_T1_en", mem_en, 0); chk("w_T1_busy", busy, 1);
        tick(); chk("w_T2_en", mem_en, 0);
        tick(); chk("w_T3_strobe", {mem_en, mem_wr}, 2'b11);
        chk("w_T3_addr", mem_addr, 16'h0010); chk("w_T3_data", mem_wdata, 16'hBEEF);
        chk("w_T3_ack", d_ack, 0);
        tick(); chk("w_T4_ack", {i_ack, d_ack}, 2'b01); chk("w_T4_en", mem_en, 0);
        d_req = 0;
        tick(); chk("w_T5_ack", d_ack, 0); chk("w_T5_busy", busy, 0);
        chk("w_count", wr_cnt, 1); chk("w_mem", mem[8], 16'hBEEF);
        // read back 0x0010
        d_req = 1; d_wr = 0; d_wdata = 16'h0000;
        tick(); tick();
        tick(); chk("r_T3_strobe", {mem_en, mem_wr}, 2'b10);
        tick(); chk("r_T4_ack", {i_ack, d_ack}, 2'b01); chk("r_T4_rdata", rdata, 16'hBEEF);
        d_req = 0;
        tick(); chk("r_count", wr_cnt, 1);
        // simultaneous I and D: D first, then I
        i_req = 1; i_addr = 16'h0012; d_req = 1; d_addr = 16'h0010;
        tick(); tick(); tick(); tick();
        chk("tie_T4_ack", {i_ack, d_ack}, 2'b01); chk("tie_T4_rdata", rdata, 16'hBEEF);
        d_req = 0;
        tick(); chk("tie_T5_busy", busy, 0); chk("tie_T5_ack", {i_ack, d_ack}, 0);
        tick(); tick();
        tick(); chk("tie_T8_strobe", {mem_en, mem_wr}, 2'b10); chk("tie_T8_addr", mem_addr, 16'h0012);
        tick(); chk("tie_T9_ack", {i_ack, d_ack}, 2'b10); chk("tie_T9_rdata", rdata, 16'h09F6);
        i_req = 0;
        tick(); chk("tie_T10_busy", busy, 0);
        // write to 0x0020 abandoned by reset at T+2
        d_req = 1; d_wr = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
        tick(); tick();
        rst = 1; d_req = 0;
        chk("ab_T2_en", mem_en, 0);
        tick(); rst = 0;
        chk("ab_busy", busy, 0); chk("ab_ack", {i_ack, d_ack}, 0); chk("ab_rdata", rdata, 16'h0000);
        chk("ab_mem", {mem_en, mem_wr, mem_addr, mem_wdata}, 0);
        tick(); tick(); chk("ab_count", wr_cnt, 1); chk("ab_noack", d_ack, 0);
        d_req = 1; d_wr = 0; d_addr = 16'h0020;
        tick(); tick(); tick(); tick();
        chk("ab_read_ack", d_ack, 1); chk("ab_read_old", rdata, 16'h10EF);
        d_req = 0;
        tick();
        // reset in the strobe cycle suppresses the write
        d_req = 1; d_wr = 1; d_addr = 16'h0022; d_wdata = 16'h5555;
        tick(); tick(); tick();
        rst = 1; d_req = 0;
        #1 chk("sup_en", {mem_en, mem_wr}, 0);
        tick(); rst = 0;
        tick(); chk("sup_count", wr_cnt, 1); chk("sup_mem", mem[17], 16'h11EE);
        // LATENCY=2 instance: strobe T+1, ack T+2, idle T+3
        i2_req = 1; i2_addr = 16'h0000;
        chk("l2_T_busy", busy2, 0);
        tick(); chk("l2_T1_strobe", {mem_en2, mem_wr2}, 2'b10); chk("l2_T1_busy", busy2, 1);
        chk("l2_T1_ack", i2_ack, 0);
        tick(); chk("l2_T2_ack", {i2_ack, d2_ack}, 2'b10); chk("l2_T2_rdata", rdata2, 16'h00FF);
        chk("l2_T2_busy", busy2, 1);
        i2_req = 0;
        tick(); chk("l2_T3_busy", busy2, 0); chk("l2_T3_ack", i2_ack, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
